// File: rtl/rng2d_pkg.sv
// Shared definitions for the RNG-2D channel: coordinate width, random-word
// width and the point generator state encoding.
package rng2d_pkg;

    localparam int COORD_W = 8;
    localparam int RND_W   = 2 * COORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rand_point_accept.sv
// Combinational rejection test for one (x, y) candidate against exclusive
// limits. A zero limit means the full coordinate range, so it always passes.
module rand_point_accept #(
    parameter int COORD_W = rng2d_pkg::COORD_W
) (
    input  logic [COORD_W-1:0] x_cand,
    input  logic [COORD_W-1:0] y_cand,
    input  logic [COORD_W-1:0] x_lim,
    input  logic [COORD_W-1:0] y_lim,
    output logic               accept
);

    logic x_ok;
    logic y_ok;

    // Each axis passes when its limit is zero or the candidate is below it.
    always_comb begin
        x_ok   = (x_lim == '0) || (x_cand < x_lim);
        y_ok   = (y_lim == '0) || (y_cand < y_lim);
        accept = x_ok && y_ok;
    end

endmodule

// File: rtl/rand_point_gen.sv
// Turns the free-running LFSR word into a bounded run of (x, y) points using
// rejection sampling, delivered over a valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; limits and count are captured on start
//   SAMPLE | testing one candidate per cycle, counting rejects
//   HOLD   | point presented, waiting for pt_ready
//   DONE   | one-cycle done pulse, then back to IDLE
module rand_point_gen #(
    parameter int COORD_W = rng2d_pkg::COORD_W,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*COORD_W-1:0] rnd_data,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_pts,
    input  logic [COORD_W-1:0]   x_lim,
    input  logic [COORD_W-1:0]   y_lim,
    output logic [COORD_W-1:0]   pt_x,
    output logic [COORD_W-1:0]   pt_y,
    output logic                 pt_valid,
    input  logic                 pt_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     reject_cnt
);

    import rng2d_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   remaining;
    logic [COORD_W-1:0] x_lim_q;
    logic [COORD_W-1:0] y_lim_q;
    logic               accept;
    logic               load;
    logic               capture;
    logic               take;
    logic               rej_inc;

    rand_point_accept #(
        .COORD_W (COORD_W)
    ) u_accept (
        .x_cand (rnd_data[COORD_W-1:0]),
        .y_cand (rnd_data[2*COORD_W-1:COORD_W]),
        .x_lim  (x_lim_q),
        .y_lim  (y_lim_q),
        .accept (accept)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the datapath strobes for each transition.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        take    = 1'b0;
        rej_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (num_pts == '0) ? DONE : SAMPLE;
                end
            end
            SAMPLE: begin
                if (accept) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    rej_inc = 1'b1;
                end
            end
            HOLD: begin
                if (pt_ready) begin
                    take    = 1'b1;
                    state_d = (remaining == CNT_W'(1)) ? DONE : SAMPLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Run parameters, point registers and the saturating reject counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining  <= '0;
            x_lim_q    <= '0;
            y_lim_q    <= '0;
            pt_x       <= '0;
            pt_y       <= '0;
            reject_cnt <= '0;
        end else begin
            if (load) begin
                remaining  <= num_pts;
                x_lim_q    <= x_lim;
                y_lim_q    <= y_lim;
                reject_cnt <= '0;
            end
            if (capture) begin
                pt_x <= rnd_data[COORD_W-1:0];
                pt_y <= rnd_data[2*COORD_W-1:COORD_W];
            end
            // remaining is nonzero whenever HOLD is reached, so no underflow.
            if (take) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (rej_inc && (reject_cnt != '1)) begin
                reject_cnt <= reject_cnt + CNT_W'(1);
            end
        end
    end

    // Status outputs are decoded straight from the registered state.
    always_comb begin
        pt_valid = (state_q == HOLD);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

endmodule

// File: tb/tb_rand_point_gen.sv
// Self-checking bench for rand_point_gen: directed scenarios plus randomized
// runs, all compared against a transaction-level reference model.
module tb_rand_point_gen;

    logic        clk;
    logic        rst;
    logic [15:0] rnd_data;
    logic        start;
    logic [15:0] num_pts;
    logic [7:0]  x_lim;
    logic [7:0]  y_lim;
    logic [7:0]  pt_x;
    logic [7:0]  pt_y;
    logic        pt_valid;
    logic        pt_ready;
    logic        busy;
    logic        done;
    logic [15:0] reject_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a run is "active"; within it either a point is
    // pending delivery or the model is searching the random stream.
    bit       m_busy;
    bit       m_pend;
    bit       m_done;
    int       m_left;
    int       m_rej;
    bit [7:0] m_xl;
    bit [7:0] m_yl;
    bit [7:0] m_px;
    bit [7:0] m_py;

    rand_point_gen #(
        .COORD_W (8),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd_data   (rnd_data),
        .start      (start),
        .num_pts    (num_pts),
        .x_lim      (x_lim),
        .y_lim      (y_lim),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .busy       (busy),
        .done       (done),
        .reject_cnt (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_range(input bit [7:0] c, input bit [7:0] lim);
        return (lim == 8'h00) || (c < lim);
    endfunction

    task automatic check_outputs();
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("pt_valid", 32'(pt_valid), 32'(m_pend));
        check_eq("reject_cnt", 32'(reject_cnt), 32'(m_rej));
        if (m_pend) begin
            check_eq("pt_x", 32'(pt_x), 32'(m_px));
            check_eq("pt_y", 32'(pt_y), 32'(m_py));
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input logic [15:0] r, input bit rdy, input bit st,
                        input logic [15:0] n, input logic [7:0] xl, input logic [7:0] yl);
        rnd_data = r;
        pt_ready = rdy;
        start    = st;
        num_pts  = n;
        x_lim    = xl;
        y_lim    = yl;
        @(posedge clk);
        if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1;
                m_pend = 1'b0;
                m_rej  = 0;
                m_left = int'(n);
                m_xl   = xl;
                m_yl   = yl;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (m_pend) begin
            if (rdy) begin
                m_pend = 1'b0;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end else begin
            if (in_range(r[7:0], m_xl) && in_range(r[15:8], m_yl)) begin
                m_pend = 1'b1;
                m_px   = r[7:0];
                m_py   = r[15:8];
            end else if (m_rej < 65535) begin
                m_rej = m_rej + 1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle_step(input logic [15:0] r, input bit rdy);
        step(r, rdy, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        m_busy = 1'b0;
        m_pend = 1'b0;
        m_done = 1'b0;
        m_left = 0;
        m_rej  = 0;
        check_eq("rst_pt_valid", 32'(pt_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_reject", 32'(reject_cnt), 32'd0);
        check_eq("rst_pt_x", 32'(pt_x), 32'd0);
        check_eq("rst_pt_y", 32'(pt_y), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        int cyc;
        logic [15:0] n;
        logic [7:0]  xl;
        logic [7:0]  yl;

        rst      = 1'b1;
        rnd_data = 16'h0000;
        start    = 1'b0;
        num_pts  = 16'd0;
        x_lim    = 8'h00;
        y_lim    = 8'h00;
        pt_ready = 1'b0;
        apply_reset();

        // Basic run, full range.
        step(16'h0000, 1'b1, 1'b1, 16'd3, 8'h00, 8'h00);
        step(16'h1234, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00);
        check_eq("basic_x0", 32'(pt_x), 32'h34);
        check_eq("basic_y0", 32'(pt_y), 32'h12);
        step(16'hABCD, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00);
        step(16'hABCD, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00);
        check_eq("basic_x1", 32'(pt_x), 32'hCD);
        check_eq("basic_y1", 32'(pt_y), 32'hAB);
        step(16'h1234, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00);
        step(16'h1234, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00);
        step(16'h5555, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00);
        check_eq("basic_done", 32'(done), 32'd1);
        check_eq("basic_rej", 32'(reject_cnt), 32'd0);
        idle_step(16'h0000, 1'b0);
        check_eq("basic_idle", 32'(busy), 32'd0);

        // Rejection against 0x10 limits.
        step(16'h0000, 1'b0, 1'b1, 16'd1, 8'h10, 8'h10);
        idle_step(16'h2005, 1'b0);
        idle_step(16'h0520, 1'b0);
        idle_step(16'h0303, 1'b0);
        check_eq("rej_x", 32'(pt_x), 32'h03);
        check_eq("rej_y", 32'(pt_y), 32'h03);
        check_eq("rej_cnt", 32'(reject_cnt), 32'd2);
        // Back-pressure: ten cycles without ready while the word changes.
        for (int i = 0; i < 10; i++) idle_step(16'($urandom), 1'b0);
        check_eq("bp_x", 32'(pt_x), 32'h03);
        check_eq("bp_valid", 32'(pt_valid), 32'd1);
        idle_step(16'h0000, 1'b1);
        check_eq("bp_done", 32'(done), 32'd1);
        idle_step(16'h0000, 1'b0);
        check_eq("rej_hold", 32'(reject_cnt), 32'd2);

        // Zero count: done on the next cycle, no point.
        step(16'h0000, 1'b1, 1'b1, 16'd0, 8'h00, 8'h00);
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_valid", 32'(pt_valid), 32'd0);
        idle_step(16'h0000, 1'b1);

        // Stray start with num_pts=5 during HOLD of a 2-point run.
        step(16'h0000, 1'b0, 1'b1, 16'd2, 8'h00, 8'h00);
        idle_step(16'h0102, 1'b0);
        step(16'h7777, 1'b0, 1'b1, 16'd5, 8'h01, 8'h01);
        idle_step(16'h0000, 1'b1);
        idle_step(16'h0304, 1'b0);
        idle_step(16'h0000, 1'b1);
        check_eq("ign_done", 32'(done), 32'd1);
        idle_step(16'h0000, 1'b0);
        check_eq("ign_idle", 32'(busy), 32'd0);

        // Reset in the middle of HOLD.
        step(16'h0000, 1'b0, 1'b1, 16'd4, 8'h80, 8'h00);
        idle_step(16'h00F0, 1'b0);
        idle_step(16'h0011, 1'b0);
        check_eq("mid_valid", 32'(pt_valid), 32'd1);
        apply_reset();
        idle_step(16'h0000, 1'b1);

        // Randomized runs with random back-pressure and stray starts.
        for (int r = 0; r < 30; r++) begin
            n  = 16'($urandom_range(0, 6));
            xl = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(64, 255));
            yl = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(64, 255));
            step(16'($urandom), 1'b0, 1'b1, n, xl, yl);
            cyc = 0;
            while (m_busy && cyc < 3000) begin
                step(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                     16'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                cyc++;
            end
            check_eq("run_idle", 32'(busy), 32'd0);
        end

        // Saturation: x byte never below 1 for 70000 cycles.
        step(16'h0000, 1'b0, 1'b1, 16'd1, 8'h01, 8'h00);
        for (int i = 0; i < 70000; i++) begin
            idle_step({8'($urandom), 8'($urandom_range(1, 255))}, 1'b1);
        end
        check_eq("sat_cnt", 32'(reject_cnt), 32'hFFFF);
        check_eq("sat_busy", 32'(busy), 32'd1);
        idle_step(16'h4200, 1'b0);
        idle_step(16'h0000, 1'b1);
        idle_step(16'h0000, 1'b0);
        check_eq("sat_hold", 32'(reject_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
